// File: rtl/fetch_sequencer.sv
// fetch_sequencer
//   Owns the program counter for the processor core and drives its DIN/Run
//   inputs. A run starts at address 0 and walks to a latched end address,
//   issuing one Run pulse per instruction and waiting for the core's Done.
//   It supports free-running or single-step execution, a Halt request that
//   takes effect at the next instruction boundary, and a watchdog on Done.
//
// Ports
//   Clock       rising-edge clock
//   Reset       synchronous active-high reset
//   Start       pulse: begin a run at address 0 (ignored while Busy)
//   Halt        stop at the next instruction boundary
//   StepMode    1 = pause after every instruction
//   StepGo      pulse: leave PAUSE and fetch the next instruction
//   EndAddr     last program address, sampled on an accepted Start
//   Done        instruction-complete from the core
//   Addr        instruction address to the core (the PC)
//   Run         one-cycle start strobe to the core
//   Busy        high outside IDLE / FINISH / ERROR
//   Finished    sticky: program reached EndAddr
//   Timeout     sticky: watchdog expired waiting for Done
//   InstrCount  instructions retired since the last accepted Start (saturating)

module fetch_sequencer #(
  parameter int ADDR_W  = 5,
  parameter int ROM_LAT = 1,
  parameter int TIMEOUT = 15,
  parameter int CNT_W   = 16
) (
  input  logic              Clock,
  input  logic              Reset,
  input  logic              Start,
  input  logic              Halt,
  input  logic              StepMode,
  input  logic              StepGo,
  input  logic [ADDR_W-1:0] EndAddr,
  input  logic              Done,
  output logic [ADDR_W-1:0] Addr,
  output logic              Run,
  output logic              Busy,
  output logic              Finished,
  output logic              Timeout,
  output logic [CNT_W-1:0]  InstrCount
);

  localparam int                LAT_W      = (ROM_LAT > 1) ? $clog2(ROM_LAT) : 1;
  localparam logic [LAT_W-1:0]  LAT_LAST   = LAT_W'(ROM_LAT - 1);
  localparam int                WAIT_W     = $clog2(TIMEOUT + 1);
  localparam logic [WAIT_W-1:0] WAIT_LIMIT = WAIT_W'(TIMEOUT);

  typedef enum logic [2:0] {
    IDLE, FETCH, ISSUE, WAIT, ADVANCE, PAUSE, FINISH, ERROR
  } state_t;

  state_t              state;
  logic [ADDR_W-1:0]   pc;
  logic [ADDR_W-1:0]   end_q;
  logic                halt_q;
  logic [LAT_W-1:0]    lat_cnt;
  logic [WAIT_W-1:0]   wait_cnt;
  logic [WAIT_W-1:0]   wait_next;

  assign Addr      = pc;
  assign wait_next = wait_cnt + 1'b1;

  always_ff @(posedge Clock) begin
    if (Reset) begin
      state      <= IDLE;
      pc         <= '0;
      end_q      <= '0;
      halt_q     <= 1'b0;
      lat_cnt    <= '0;
      wait_cnt   <= '0;
      Run        <= 1'b0;
      Busy       <= 1'b0;
      Finished   <= 1'b0;
      Timeout    <= 1'b0;
      InstrCount <= '0;
    end else begin
      Run <= 1'b0;

      // Halt never aborts an instruction; it is only remembered here and
      // acted on in ADVANCE once the core has reported Done.
      if ((state == FETCH || state == ISSUE || state == WAIT) && Halt)
        halt_q <= 1'b1;

      case (state)
        IDLE, FINISH, ERROR: begin
          if (Start) begin
            pc         <= '0;
            end_q      <= EndAddr;
            halt_q     <= 1'b0;
            lat_cnt    <= '0;
            Finished   <= 1'b0;
            Timeout    <= 1'b0;
            InstrCount <= '0;
            Busy       <= 1'b1;
            state      <= FETCH;
          end
        end

        FETCH: begin
          if (lat_cnt == LAT_LAST) begin
            Run      <= 1'b1;
            wait_cnt <= '0;
            state    <= ISSUE;
          end else begin
            lat_cnt <= lat_cnt + 1'b1;
          end
        end

        ISSUE: state <= WAIT;

        WAIT: begin
          // Done takes priority over a watchdog expiry in the same cycle.
          if (Done) begin
            state <= ADVANCE;
          end else if (wait_next == WAIT_LIMIT) begin
            Timeout <= 1'b1;
            Busy    <= 1'b0;
            state   <= ERROR;
          end else begin
            wait_cnt <= wait_next;
          end
        end

        ADVANCE: begin
          if (InstrCount != '1)
            InstrCount <= InstrCount + 1'b1;
          if (pc == end_q) begin
            Finished <= 1'b1;
            Busy     <= 1'b0;
            state    <= FINISH;
          end else if (halt_q) begin
            pc     <= pc + 1'b1;
            halt_q <= 1'b0;
            Busy   <= 1'b0;
            state  <= IDLE;
          end else if (StepMode) begin
            pc    <= pc + 1'b1;
            state <= PAUSE;
          end else begin
            pc      <= pc + 1'b1;
            lat_cnt <= '0;
            state   <= FETCH;
          end
        end

        PAUSE: begin
          if (Halt) begin
            Busy  <= 1'b0;
            state <= IDLE;
          end else if (StepGo) begin
            lat_cnt <= '0;
            state   <= FETCH;
          end
        end

        default: begin
          Busy  <= 1'b0;
          state <= IDLE;
        end
      endcase
    end
  end

endmodule

// File: tb/tb_fetch_sequencer.sv
// Directed bench for fetch_sequencer. A small core model answers each Run
// with Done after a per-address latency (0 = never answers) and checks that
// Addr holds while the instruction is in flight.

module tb_fetch_sequencer;

  logic        Clock = 1'b0;
  logic        Reset;
  logic        Start;
  logic        Halt;
  logic        StepMode;
  logic        StepGo;
  logic [4:0]  EndAddr;
  logic        Done;
  logic [4:0]  Addr;
  logic        Run;
  logic        Busy;
  logic        Finished;
  logic        Timeout;
  logic [15:0] InstrCount;

  int errors = 0;
  int checks = 0;
  int cyc    = 0;
  int t0     = 0;

  int         lat_mem [32];
  int         core_cnt = 0;
  logic [4:0] run_addr = '0;
  int         run_t [$];
  logic [4:0] run_a [$];

  fetch_sequencer #(
    .ADDR_W (5),
    .ROM_LAT(1),
    .TIMEOUT(15),
    .CNT_W  (16)
  ) dut (
    .Clock     (Clock),
    .Reset     (Reset),
    .Start     (Start),
    .Halt      (Halt),
    .StepMode  (StepMode),
    .StepGo    (StepGo),
    .EndAddr   (EndAddr),
    .Done      (Done),
    .Addr      (Addr),
    .Run       (Run),
    .Busy      (Busy),
    .Finished  (Finished),
    .Timeout   (Timeout),
    .InstrCount(InstrCount)
  );

  always #5 Clock = ~Clock;

  always @(posedge Clock) cyc++;

  task automatic check(input string tag, input logic [31:0] obs, input logic [31:0] exp);
    checks++;
    assert (obs === exp) else begin
      errors++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  // Core model: Done is high in cycle k+lat for a Run in cycle k.
  always @(negedge Clock) begin
    Done = 1'b0;
    if (!Busy) core_cnt = 0;
    if (core_cnt > 0) begin
      check("addr_hold", {27'd0, Addr}, {27'd0, run_addr});
      core_cnt--;
      if (core_cnt == 0) Done = 1'b1;
    end
    if (Run) begin
      run_t.push_back(cyc);
      run_a.push_back(Addr);
      run_addr = Addr;
      core_cnt = lat_mem[Addr];
    end
  end

  task automatic tick(input int n);
    repeat (n) @(negedge Clock);
  endtask

  // Leaves the bench at the negedge of the first FETCH cycle (c0).
  task automatic do_start(input logic [4:0] e);
    Start   = 1'b1;
    EndAddr = e;
    tick(1);
    Start = 1'b0;
    t0    = cyc;
    run_t.delete();
    run_a.delete();
  endtask

  task automatic set_lat(input int v);
    for (int i = 0; i < 32; i++) lat_mem[i] = v;
  endtask

  initial begin
    Reset = 1'b1; Start = 1'b0; Halt = 1'b0; StepMode = 1'b0;
    StepGo = 1'b0; EndAddr = '0; Done = 1'b0;
    set_lat(1);
    tick(2);
    check("rst_run",   Run, 0);
    check("rst_addr",  Addr, 0);
    check("rst_busy",  Busy, 0);
    check("rst_fin",   Finished, 0);
    check("rst_to",    Timeout, 0);
    check("rst_count", InstrCount, 0);
    Reset = 1'b0;
    tick(1);

    // Basic run: three single-cycle ops, EndAddr=2.
    do_start(5'd2);
    check("basic_busy_c0", Busy, 1);
    tick(11);
    check("basic_fin_c11", Finished, 0);
    check("basic_busy_c11", Busy, 1);
    tick(1);
    check("basic_fin_c12", Finished, 1);
    check("basic_count", InstrCount, 3);
    check("basic_busy_end", Busy, 0);
    check("basic_nrun", run_t.size(), 3);
    for (int i = 0; i < 3; i++) begin
      check("basic_run_t", run_t[i] - t0, 1 + 4 * i);
      check("basic_run_a", {27'd0, run_a[i]}, i);
    end

    // Mixed run from FINISH: add at 0, mv at 1, EndAddr=1.
    lat_mem[0] = 3;
    do_start(5'd1);
    check("mixed_fin_clr", Finished, 0);
    check("mixed_cnt_clr", InstrCount, 0);
    tick(10);
    check("mixed_fin", Finished, 1);
    check("mixed_count", InstrCount, 2);
    check("mixed_nrun", run_t.size(), 2);
    check("mixed_run0_t", run_t[0] - t0, 1);
    check("mixed_run1_t", run_t[1] - t0, 7);

    // Watchdog: instruction at address 1 never completes.
    set_lat(1);
    lat_mem[1] = 0;
    do_start(5'd3);
    tick(20);
    check("wd_to_c20", Timeout, 0);
    check("wd_busy_c20", Busy, 1);
    tick(1);
    check("wd_to_c21", Timeout, 1);
    check("wd_busy_c21", Busy, 0);
    check("wd_addr", Addr, 1);
    check("wd_count", InstrCount, 1);
    tick(5);
    check("wd_nrun", run_t.size(), 2);
    check("wd_run1_t", run_t[1] - t0, 5);
    lat_mem[1] = 1;
    do_start(5'd0);
    check("wd_restart_to", Timeout, 0);
    check("wd_restart_addr", Addr, 0);
    check("wd_restart_cnt", InstrCount, 0);
    tick(4);
    check("wd_restart_fin", Finished, 1);
    check("wd_restart_count", InstrCount, 1);
    check("wd_restart_run_a", {27'd0, run_a[0]}, 0);

    // Halt during WAIT of the add at address 1.
    lat_mem[1] = 3;
    do_start(5'd4);
    tick(6);
    Halt = 1'b1;
    tick(1);
    Halt = 1'b0;
    tick(2);
    check("halt_busy_c9", Busy, 1);
    check("halt_count_c9", InstrCount, 1);
    tick(1);
    check("halt_busy", Busy, 0);
    check("halt_addr", Addr, 2);
    check("halt_count", InstrCount, 2);
    check("halt_fin", Finished, 0);
    tick(8);
    check("halt_nrun", run_t.size(), 2);

    // Step mode.
    set_lat(1);
    StepMode = 1'b1;
    do_start(5'd3);
    tick(4);
    check("step_busy_p1", Busy, 1);
    check("step_addr_p1", Addr, 1);
    check("step_count_p1", InstrCount, 1);
    tick(3);
    check("step_busy_hold", Busy, 1);
    check("step_nrun_hold", run_t.size(), 1);
    StepGo = 1'b1;
    tick(1);
    StepGo = 1'b0;
    tick(4);
    check("step_addr_p2", Addr, 2);
    check("step_count_p2", InstrCount, 2);
    check("step_busy_p2", Busy, 1);
    check("step_nrun_p2", run_t.size(), 2);
    check("step_run1_t", run_t[1] - t0, 9);
    StepGo = 1'b1;
    Halt   = 1'b1;
    tick(1);
    StepGo = 1'b0;
    Halt   = 1'b0;
    check("step_halt_busy", Busy, 0);
    check("step_halt_addr", Addr, 2);
    check("step_halt_count", InstrCount, 2);
    tick(4);
    check("step_halt_nrun", run_t.size(), 2);
    StepMode = 1'b0;

    // Reset in WAIT of the add at address 1, with Start held alongside.
    lat_mem[1] = 3;
    do_start(5'd3);
    tick(6);
    Reset = 1'b1;
    Start = 1'b1;
    tick(1);
    check("mrst_run",   Run, 0);
    check("mrst_addr",  Addr, 0);
    check("mrst_count", InstrCount, 0);
    check("mrst_fin",   Finished, 0);
    check("mrst_to",    Timeout, 0);
    check("mrst_busy",  Busy, 0);
    Reset = 1'b0;
    Start = 1'b0;
    tick(1);
    check("mrst_busy_after", Busy, 0);
    check("mrst_run_after", Run, 0);

    $display("Result: errors=%0d of %0d checks", errors, checks);
    $finish;
  end

endmodule

// File: doc/fetch_sequencer.md
# fetch_sequencer

Program sequencer that sits directly upstream of the processor core. It owns the program counter and drives the core's 5-bit instruction address input (`DIN`) and its `Run` strobe. It then waits for the core's `Done`, advances through the program from address 0 to a programmable end address, and flags completion or a hung instruction. It replaces manual switch/button driving of `DIN`/`Run` with autonomous or single-step program execution.

## Interface
- `ADDR_W`, default 5: address width; matches the core's `DIN` and instruction-memory depth.
- `ROM_LAT`, default 1: instruction-memory read latency in cycles; the memory is clocked.
- `TIMEOUT`, default 15: maximum WAIT cycles allowed without `Done`.
- `CNT_W`, default 16: retired-instruction counter width.

- `Clock`, in, 1: single clock; all state updates on rising edge.
- `Reset`, in, 1: synchronous, active-high reset.
- `Start`, in, 1: one-cycle pulse; begins a program run at address 0.
- `Halt`, in, 1: requests a stop at the next instruction boundary.
- `StepMode`, in, 1: 1 means pause after every instruction.
- `StepGo`, in, 1: one-cycle pulse; releases a PAUSE.
- `EndAddr`, in, `ADDR_W`: last program address; sampled on accepted `Start`.
- `Done`, in, 1: instruction-complete signal from the core.
- `Addr`, out, `ADDR_W`: instruction address to the core's `DIN`; always equals the PC.
- `Run`, out, 1: start strobe to the core.
- `Busy`, out, 1: high in every state except IDLE, FINISH and ERROR.
- `Finished`, out, 1: program ran to `EndAddr`; sticky.
- `Timeout`, out, 1: watchdog expired; sticky.
- `InstrCount`, out, `CNT_W`: number of instructions retired since the last accepted `Start`.

## Operation
- States:
  - IDLE
  - FETCH: waits `ROM_LAT` cycles for the memory output to settle.
  - ISSUE: `Run`=1 for exactly one cycle.
  - WAIT: waits for `Done`.
  - ADVANCE: retires the instruction.
  - PAUSE
  - FINISH
  - ERROR
- **Reset:** state=IDLE, PC=0, `Run`=0, `Finished`=0, `Timeout`=0, `InstrCount`=0, halt latch=0, latched EndAddr=0.
- **Start:** accepted in IDLE, FINISH or ERROR. It sets PC=0, latches `EndAddr`, clears `Finished`, `Timeout` and `InstrCount`, and goes to FETCH. `Start` is ignored while `Busy`.
- **FETCH:** holds `ROM_LAT` cycles, then goes to ISSUE.
- **ISSUE:** goes to WAIT unconditionally. `Done` seen in ISSUE is ignored.
- **WAIT:**
  - `Done`=1 goes to ADVANCE.
  - Otherwise the wait counter increments. When the counter reaches `TIMEOUT`, the block goes to ERROR and sets `Timeout`=1.
  - If `Done` and expiry occur in the same cycle, `Done` wins.
- **ADVANCE:** `InstrCount` increments, saturating at all-ones. Then, in priority order:
  1. PC==latched EndAddr: go to FINISH and set `Finished`=1. PC is not incremented.
  2. Halt latch set: go to IDLE, PC += 1, clear the halt latch.
  3. `StepMode`=1: PC += 1, go to PAUSE.
  4. Otherwise: PC += 1, go to FETCH.
- **PAUSE:** `StepGo` goes to FETCH. `Halt` goes to IDLE. If both arrive together, `Halt` wins.
- **Halt:** latched when it arrives in FETCH, ISSUE or WAIT. It is never allowed to abort an instruction the core has started. It is ignored in IDLE, FINISH and ERROR.
- **PC wrap:** PC arithmetic is modulo 2^`ADDR_W`. Termination always occurs at `EndAddr` before any wrap, because runs start at 0.
- **Resume after Halt:** IDLE keeps the PC, but a new `Start` restarts at 0.

## Timing
- `Run` is a registered output, high only in ISSUE, for exactly one cycle per instruction.
- `Addr` is registered and stable from FETCH entry until the ADVANCE exit edge. It never changes while `Run`=1 or during WAIT.
- If `Run` is in cycle k, the core's `Done` arrives no earlier than k+1.
- Per-instruction latency with `ROM_LAT`=1:
  - Single-cycle core op (`mv`/`mvt`, `Done` at k+1): 4 cycles (FETCH, ISSUE, WAIT, ADVANCE).
  - `add`/`sub` (`Done` at k+3): 6 cycles.
- `Finished`, `Timeout` and `InstrCount` update on the edge leaving ADVANCE (or WAIT for `Timeout`).
- A `Reset` asserted in any state takes effect at the next edge and overrides all other inputs.

## Test plan
- **Basic run:** `EndAddr`=2, three `mv` instructions, `Start` pulse → three `Run` pulses spaced 4 cycles apart at `Addr`=0,1,2; `Finished`=1 and `InstrCount`=3 are seen 12 cycles after FETCH entry; `Busy`=0.
- **Mixed run:** `add` at address 0, `mv` at address 1, `EndAddr`=1 → `Run` pulses 6 cycles apart; `InstrCount`=2; `Addr` is never changed during WAIT.
- **Watchdog:** `Done` tied low → `Timeout`=1 exactly 15 WAIT cycles after `Run`; state=ERROR; `Run` is never reasserted; a later `Start` clears `Timeout` and restarts at `Addr`=0.
- **Halt mid-instruction:** `Halt` pulsed during WAIT of the `add` at address 1 → that `add` completes, `InstrCount`=2, IDLE with PC=2, and there is no further `Run`.
- **Step mode:** `StepMode`=1, `EndAddr`=3 → one instruction per `StepGo`; `Busy` stays 1 in PAUSE; `StepGo` and `Halt` pulsed in the same cycle → IDLE.
- **Reset mid-WAIT:** `Reset` asserted in WAIT → next cycle `Run`=0, `Addr`=0, `InstrCount`=0, `Finished`=0, `Timeout`=0, state=IDLE; `Start` during `Reset` is ignored.
